// File: rtl/spart_frac_baud_gen_if.sv
// Control/status bundle between the SPART core and its fractional baud generator.
interface spart_frac_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic                      wr_en;
  logic [1:0]                ioaddr;
  logic [7:0]                databus;
  logic                      en;
  logic                      clr;
  logic                      ovs_tick;
  logic                      baud_tick;
  logic [DIV_W+FRAC_W-1:0]   div_active;

  modport master (
    output wr_en, ioaddr, databus, en, clr,
    input  ovs_tick, baud_tick, div_active
  );

  modport slave (
    input  wr_en, ioaddr, databus, en, clr,
    output ovs_tick, baud_tick, div_active
  );
endinterface

// File: rtl/spart_frac_baud_gen.sv
// Fractional baud generator: oversample and bit-rate ticks derived from a
// double-buffered integer+fractional divisor committed atomically.
module spart_frac_baud_gen #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVS        = 16,
  parameter int RESET_DIV  = 325,
  parameter int RESET_FRAC = 0
) (
  input logic                  clk,
  input logic                  rst,
  spart_frac_baud_gen_if.slave bus
);
  localparam int OCNT_W = $clog2(OVS);
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_DIV);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_FRAC);
  localparam logic [OCNT_W-1:0] OVS_LAST = OCNT_W'(OVS - 1);

  logic [DIV_W-1:0]  r_shadowInt;
  logic [DIV_W-1:0]  r_activeInt;
  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_shadowFrac;
  logic [FRAC_W-1:0] r_activeFrac;
  logic [FRAC_W-1:0] r_acc;
  logic [OCNT_W-1:0] r_ovsCnt;
  logic              r_ovsTick;
  logic              r_baudTick;

  logic              w_commit;
  logic [DIV_W-1:0]  w_commitInt;
  logic [DIV_W-1:0]  w_nextActiveInt;
  logic [DIV_W-1:0]  w_reloadCnt;
  logic [FRAC_W:0]   w_accSum;
  logic [DIV_W:0]    w_reloadSum;

  assign w_commit        = bus.wr_en && (bus.ioaddr == 2'b11);
  assign w_commitInt     = {bus.databus[DIV_W-9:0], r_shadowInt[7:0]};
  assign w_nextActiveInt = w_commit ? w_commitInt : r_activeInt;
  assign w_accSum        = {1'b0, r_acc} + {1'b0, r_activeFrac};
  assign w_reloadSum     = {1'b0, r_activeInt} + {{DIV_W{1'b0}}, w_accSum[FRAC_W]};
  // A carry into an all-ones divisor would wrap to zero, so clamp it.
  assign w_reloadCnt     = w_reloadSum[DIV_W] ? {DIV_W{1'b1}} : w_reloadSum[DIV_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadowInt  <= RST_INT;
      r_shadowFrac <= RST_FRAC;
      r_activeInt  <= RST_INT;
      r_activeFrac <= RST_FRAC;
    end else if (bus.wr_en) begin
      case (bus.ioaddr)
        2'b00: r_shadowFrac <= bus.databus[FRAC_W-1:0];
        2'b10: r_shadowInt[7:0] <= bus.databus;
        2'b11: begin
          r_shadowInt  <= w_commitInt;
          r_activeInt  <= w_commitInt;
          r_activeFrac <= r_shadowFrac;
        end
        default: ;
      endcase
    end
  end

  // The active divisor is only sampled at reload, so a commit never cuts a period short.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_ovsCnt   <= '0;
      r_ovsTick  <= 1'b0;
      r_baudTick <= 1'b0;
    end else if (bus.clr) begin
      r_cnt      <= w_nextActiveInt;
      r_acc      <= '0;
      r_ovsCnt   <= '0;
      r_ovsTick  <= 1'b0;
      r_baudTick <= 1'b0;
    end else if (bus.en) begin
      if (r_cnt != '0) begin
        r_cnt      <= r_cnt - 1'b1;
        r_ovsTick  <= 1'b0;
        r_baudTick <= 1'b0;
      end else begin
        r_cnt     <= w_reloadCnt;
        r_acc     <= w_accSum[FRAC_W-1:0];
        r_ovsTick <= 1'b1;
        if (r_ovsCnt == OVS_LAST) begin
          r_ovsCnt   <= '0;
          r_baudTick <= 1'b1;
        end else begin
          r_ovsCnt   <= r_ovsCnt + 1'b1;
          r_baudTick <= 1'b0;
        end
      end
    end else begin
      r_ovsTick  <= 1'b0;
      r_baudTick <= 1'b0;
    end
  end

  assign bus.ovs_tick   = r_ovsTick;
  assign bus.baud_tick  = r_baudTick;
  assign bus.div_active = {r_activeInt, r_activeFrac};
endmodule
